// File: rtl/afifo_wr_arb.sv
// afifo_wr_arb: round-robin arbiter sharing one AFIFO write port among NUM_REQ requesters (clk_wr domain).
// Latency: 1 bubble cycle per arbitration, then up to MAX_BURST beats at 1 beat/cycle; TIMEOUT idle cycles force release.
// Backpressure: fifo_full stalls the granted requester (req_ready low) without counting toward the timeout.
// Optional build macro AFIFO_WR_ARB_PRIO_EN: requester 0 wins every arbitration it participates in.
module afifo_wr_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int TIMEOUT    = 8,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int BW  = $clog2(MAX_BURST) + 1,
  localparam int TW  = $clog2(TIMEOUT + 1)
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [IDW-1:0]                gnt_id,
  output logic                          busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Beat count / idle count values at which the current beat or idle cycle ends the grant.
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT - 1);

  state_t         state;
  logic [IDW-1:0] rr_last;
  logic [BW-1:0]  beat_cnt;
  logic [TW-1:0]  idle_cnt;

  logic           cur_valid;
  logic           cur_last;
  logic           pick_vld;
  logic [IDW-1:0] pick_id;
  logic           prio_hit;
  int             rr_idx;

  assign busy      = (state == GRANT);
  assign cur_valid = req_valid[gnt_id];
  assign cur_last  = req_last[gnt_id];

  // Write port: a beat moves only when granted, valid, FIFO has room and not in reset.
  assign fifo_wr_en = busy & cur_valid & ~fifo_full & rst_wr_n;
  assign fifo_wdata = req_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];

  // Only the granted requester sees ready, gated by full and reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = busy && (IDW'(i) == gnt_id) && !fifo_full && rst_wr_n;
    end
  end

  // Round-robin pick: first valid index after rr_last, wrapping; descending loop so the nearest wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = rr_last;
    rr_idx   = 0;
    prio_hit = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_idx = (int'(rr_last) + k) % NUM_REQ;
      if (req_valid[rr_idx]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'(rr_idx);
      end
    end
`ifdef AFIFO_WR_ARB_PRIO_EN
    if (req_valid[0]) begin
      prio_hit = 1'b1;
      pick_id  = '0;
    end
`endif
  end

  // Arbitration FSM: IDLE picks a requester, GRANT streams its beats until last, burst limit or timeout.
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      state    <= IDLE;
      gnt_id   <= '0;
      rr_last  <= IDW'(NUM_REQ - 1);
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state    <= GRANT;
            gnt_id   <= pick_id;
            beat_cnt <= '0;
            idle_cnt <= '0;
            // A priority grant to requester 0 leaves the rotation untouched.
            if (!prio_hit) rr_last <= pick_id;
          end
        end
        GRANT: begin
          if (fifo_full) begin
            // Backpressure: hold grant and both counters.
            state <= GRANT;
          end else if (cur_valid) begin
            idle_cnt <= '0;
            if (cur_last || (beat_cnt == BURST_LAST)) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            state    <= IDLE;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Directed bench for afifo_wr_arb: requester queues drive beats, a scoreboard holds the expected beat order.
// Outputs are sampled on the falling edge; inputs change just after the rising edge.
module tb_afifo_wr_arb;
  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst_wr_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_last = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic              fifo_full = 1'b0;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wdata;
  logic [IDW-1:0]    gnt_id;
  logic              busy;

  afifo_wr_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(4), .TIMEOUT(8)) dut (
    .clk_wr(clk), .rst_wr_n(rst_wr_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;

  logic [DW:0]       rq [NR][$];
  logic [IDW+DW-1:0] sb [$];
  int                xq [$];
  int                gq [$];
  bit                hs_vld = 1'b0;
  int                hs_id  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]           = 1'b1;
        req_last[i]            = rq[i][0][DW];
        req_data[i*DW +: DW]   = rq[i][0][DW-1:0];
      end else begin
        req_valid[i]           = 1'b0;
        req_last[i]            = 1'b0;
        req_data[i*DW +: DW]   = '0;
      end
    end
  endtask

  task automatic beat(input int id, input logic [DW-1:0] d, input bit l);
    rq[id].push_back({l, d});
    drive();
  endtask

  task automatic expect_beat(input int id, input logic [DW-1:0] d);
    sb.push_back({IDW'(id), d});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic bit all_empty();
    bit e = (sb.size() == 0);
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string tag, input int max);
    for (int i = 0; i < max && !all_empty(); i++) steps(1);
    chk(tag, sb.size(), 0);
  endtask

  task automatic clear_log();
    xq.delete();
    gq.delete();
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every write is checked against the scoreboard head.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      xq.push_back(cyc);
      gq.push_back(int'(gnt_id));
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) chk("beat", {gnt_id, fifo_wdata}, sb.pop_front());
      hs_vld = 1'b1;
      hs_id  = int'(gnt_id);
    end
  end

  // Requester side: retire the accepted beat and present the next one.
  always @(posedge clk) begin
    #1;
    if (hs_vld) begin
      if (rq[hs_id].size() > 0) void'(rq[hs_id].pop_front());
      hs_vld = 1'b0;
    end
    drive();
  end

  int c0;
  int ord [8];

  initial begin
    // Reset values
    drive();
    steps(2);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt_id, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_ready", req_ready, 0);
    rst_wr_n = 1'b1;
    steps(1);

    // Single requester, 3-beat packet
    clear_log();
    c0 = cyc;
    beat(1, 32'hA0, 0); beat(1, 32'hA1, 0); beat(1, 32'hA2, 1);
    expect_beat(1, 32'hA0); expect_beat(1, 32'hA1); expect_beat(1, 32'hA2);
    #1;
    chk("t1_bubble_busy", busy, 0);
    chk("t1_bubble_wr_en", fifo_wr_en, 0);
    steps(1);
    chk("t1_busy", busy, 1);
    chk("t1_gnt", gnt_id, 1);
    chk("t1_ready", req_ready, 4'b0010);
    steps(3);
    chk("t1_release", busy, 0);
    chk("t1_gnt_hold", gnt_id, 1);
    chk("t1_nbeats", xq.size(), 3);
    if (xq.size() == 3) begin
      chk("t1_beat0_cyc", xq[0], c0 + 1);
      chk("t1_beat2_cyc", xq[2], c0 + 3);
    end

    // Round-robin fairness, fresh rotation
    rst_wr_n = 1'b0;
    steps(1);
    rst_wr_n = 1'b1;
    clear_log();
`ifdef AFIFO_WR_ARB_PRIO_EN
    ord = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    begin
      int nxt [NR];
      for (int i = 0; i < NR; i++) nxt[i] = 0;
      for (int g = 0; g < 8; g++) begin
        for (int k = 0; k < 4; k++) begin
          expect_beat(ord[g], 32'hB000_0000 | (ord[g] << 8) | nxt[ord[g]]);
          nxt[ord[g]]++;
        end
      end
    end
    for (int id = 0; id < NR; id++)
      for (int n = 0; n < 8; n++) beat(id, 32'hB000_0000 | (id << 8) | n, n == 7);
    drain("t2_drain", 300);
    chk("t2_nbeats", xq.size(), 32);
    for (int k = 0; k < 32 && k < xq.size(); k++) begin
      chk("t2_order", gq[k], ord[k/4]);
      if (k > 0) chk("t2_spacing", xq[k] - xq[k-1], (k % 4 == 0) ? 2 : 1);
    end

    // Full stall mid-burst from requester 2
    steps(2);
    clear_log();
    c0 = cyc;
    for (int n = 0; n < 4; n++) begin
      beat(2, 32'hC0 + n, 0);
      expect_beat(2, 32'hC0 + n);
    end
    steps(3);
    fifo_full = 1'b1;
    #1;
    for (int j = 0; j < 5; j++) begin
      chk("t3_stall_wr_en", fifo_wr_en, 0);
      chk("t3_stall_ready", req_ready, 0);
      chk("t3_stall_busy", busy, 1);
      steps(1);
    end
    fifo_full = 1'b0;
    drain("t3_drain", 20);
    steps(1);
    chk("t3_release", busy, 0);
    chk("t3_nbeats", xq.size(), 4);
    if (xq.size() == 4) begin
      chk("t3_beat2_cyc", xq[1], c0 + 2);
      chk("t3_beat3_cyc", xq[2], c0 + 8);
      chk("t3_beat4_cyc", xq[3], c0 + 9);
    end

    // Timeout release of requester 3, then pending requester 0
    steps(1);
    clear_log();
    c0 = cyc;
    beat(3, 32'hD0, 0);
    expect_beat(3, 32'hD0);
    steps(2);
    beat(0, 32'hE0, 0); beat(0, 32'hE1, 1);
    expect_beat(0, 32'hE0); expect_beat(0, 32'hE1);
    steps(7);
    chk("t4_still_busy", busy, 1);
    chk("t4_still_gnt", gnt_id, 3);
    steps(1);
    chk("t4_timeout", busy, 0);
    steps(1);
    chk("t4_next_busy", busy, 1);
    chk("t4_next_gnt", gnt_id, 0);
    drain("t4_drain", 20);
    if (xq.size() >= 2) chk("t4_resume_cyc", xq[1], c0 + 11);

    // Reset during beat 2 of requester 1
    steps(2);
    clear_log();
    c0 = cyc;
    for (int n = 0; n < 4; n++) beat(1, 32'hF0 + n, 0);
    expect_beat(1, 32'hF0);
    steps(2);
    rst_wr_n = 1'b0;
    #1;
    chk("t5_rst_wr_en", fifo_wr_en, 0);
    chk("t5_rst_ready", req_ready, 0);
    rq[1].delete();
    drive();
    steps(1);
    chk("t5_busy", busy, 0);
    chk("t5_gnt", gnt_id, 0);
    rst_wr_n = 1'b1;
    clear_log();
    for (int id = 0; id < NR; id++) begin
      beat(id, 32'h5A00 + id, 1);
      expect_beat(id, 32'h5A00 + id);
    end
    drain("t5_drain", 40);
    if (gq.size() > 0) chk("t5_first_gnt", gq[0], 0);

    // Requesters 0 and 2 continuously valid, single-beat packets
    steps(2);
    clear_log();
`ifdef AFIFO_WR_ARB_PRIO_EN
    ord = '{0, 0, 0, 0, 2, 2, 2, 2};
`else
    ord = '{0, 2, 0, 2, 0, 2, 0, 2};
`endif
    begin
      int n0 = 0;
      int n2 = 0;
      for (int g = 0; g < 8; g++) begin
        if (ord[g] == 0) begin expect_beat(0, 32'h6000 + n0); n0++; end
        else             begin expect_beat(2, 32'h6200 + n2); n2++; end
      end
    end
    for (int n = 0; n < 4; n++) begin
      beat(0, 32'h6000 + n, 1);
      beat(2, 32'h6200 + n, 1);
    end
    drain("t6_drain", 60);
    chk("t6_nbeats", gq.size(), 8);
    for (int g = 0; g < 8 && g < gq.size(); g++) chk("t6_order", gq[g], ord[g]);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
